apb_slave_bridge: RTL and testbench

- Parametrised APB3/APB4 slave front-end bridging the APB bus to the UART SFR back-end.
- Registers each APB transfer and issues a single-cycle read or write request to the back-end.
- Supports variable back-end wait states, byte strobes, back-end error reporting, and a watchdog timeout that terminates hung transfers with PSLVERR.

---
 rtl/apb_slave_bridge_pkg.sv | 24 ++
 rtl/apb_slave_bridge_if.sv | 38 +++
 rtl/apb_slave_bridge_timeout_cnt.sv | 42 ++++
 rtl/apb_slave_bridge.sv | 162 ++++++++++++++++
 tb/tb_apb_slave_bridge.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_slave_bridge_pkg.sv
// Shared types and helpers for the APB slave bridge.
// Holds the FSM state encoding, the watchdog counter width function
// and the address alignment check.
package apb_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } apb_state_e;

    // Bits needed to hold TIMEOUT-1; never narrower than one bit.
    function automatic int cnt_width(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

    // True when the byte address is aligned to a full data word of strb_w bytes.
    function automatic logic is_aligned(input logic [63:0] addr, input int strb_w);
        logic [63:0] mask;
        mask = 64'(strb_w) - 64'd1;
        return (addr & mask) == 64'd0;
    endfunction

endpackage

// File: rtl/apb_slave_bridge_if.sv
// APB3/APB4 bus bundle between an APB master and the UART SFR bridge.
// With APB_PROT_EN defined the bundle also carries pprot.
interface apb_slave_bridge_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
`ifdef APB_PROT_EN
    logic [2:0]        pprot;
`endif
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
`ifdef APB_PROT_EN
        output pprot,
`endif
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
`ifdef APB_PROT_EN
        input  pprot,
`endif
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_slave_bridge_timeout_cnt.sv
// Watchdog for back-end wait states. A down-counter loaded with TIMEOUT-1
// on clear and decremented while enabled; expired_o flags terminal count.
module apb_timeout_cnt
    import apb_slave_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic pclk,
    input  logic presetn,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int            CW   = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: reload on clear, otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = LOAD;
        end else if (enable_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Count register; resets to the reload value so it is not expired when idle.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/apb_slave_bridge.sv
// APB3/APB4 slave front-end for the UART SFR back-end.
// Registers each APB transfer, issues one single-cycle read or write request
// to the back-end, waits for ready_i (bounded by a watchdog) and returns a
// one-cycle pready with prdata/pslverr. All outputs are registered.
// Build option APB_PROT_EN: adds pprot on the bus and rejects non-secure
// accesses at or above SECURE_BASE.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no transfer; accepts a setup phase (psel=1, penable=0)
// WAIT    | request issued, waiting for back-end ready_i or watchdog
// RESP    | pready=1 for one cycle with prdata/pslverr valid
module apb_slave_bridge
    import apb_slave_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
`ifdef APB_PROT_EN
    ,
    parameter logic [ADDR_W-1:0] SECURE_BASE = 'h800
`endif
) (
    input  logic                    pclk,
    input  logic                    presetn,
    apb_slave_bridge_if.slave       apb,
    output logic                    wr_en_o,
    output logic                    rd_en_o,
    output logic [ADDR_W-1:0]       addr_o,
    output logic [DATA_W-1:0]       wdata_o,
    output logic [DATA_W/8-1:0]     wstrb_o,
    input  logic [DATA_W-1:0]       rdata_i,
    input  logic                    ready_i,
    input  logic                    err_i
);

    localparam int STRB_W = DATA_W / 8;

    apb_state_e        state_q;
    logic              write_q;
    logic              wr_en_q;
    logic              rd_en_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [DATA_W-1:0] prdata_q;
    logic              pready_q;
    logic              pslverr_q;

    logic              setup;
    logic              misaligned;
    logic              blocked;
    logic              reject;
    logic              accept;
    logic              expired;

    assign setup      = apb.psel && !apb.penable;
    assign misaligned = !is_aligned(64'(apb.paddr), STRB_W);

`ifdef APB_PROT_EN
    assign blocked    = apb.pprot[1] && (apb.paddr >= SECURE_BASE);
`else
    assign blocked    = 1'b0;
`endif

    // Rejected setups go straight to an error response without a request.
    assign reject     = misaligned || blocked;
    assign accept     = (state_q == ST_IDLE) && setup && !reject;

    apb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .pclk      (pclk),
        .presetn   (presetn),
        .clear_i   (accept),
        .enable_i  (state_q == ST_WAIT),
        .expired_o (expired)
    );

    // Transfer FSM with all bus and back-end outputs registered alongside it.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= ST_IDLE;
            write_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            // Requests are single-cycle pulses only in the cycle after setup.
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    prdata_q  <= '0;
                    if (setup) begin
                        addr_q  <= apb.paddr;
                        wdata_q <= apb.pwdata;
                        wstrb_q <= apb.pwrite ? apb.pstrb : '0;
                        write_q <= apb.pwrite;
                        if (reject) begin
                            state_q   <= ST_RESP;
                            pready_q  <= 1'b1;
                            pslverr_q <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT;
                            wr_en_q <= apb.pwrite;
                            rd_en_q <= !apb.pwrite;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!apb.psel) begin
                        // Master abandoned the transfer; drop any late back-end reply.
                        state_q   <= ST_IDLE;
                        prdata_q  <= '0;
                        pslverr_q <= 1'b0;
                        pready_q  <= 1'b0;
                    end else if (ready_i) begin
                        state_q   <= ST_RESP;
                        prdata_q  <= write_q ? '0 : rdata_i;
                        pslverr_q <= err_i;
                        pready_q  <= 1'b1;
                    end else if (expired) begin
                        state_q   <= ST_RESP;
                        prdata_q  <= '0;
                        pslverr_q <= 1'b1;
                        pready_q  <= 1'b1;
                    end
                end
                ST_RESP: begin
                    state_q   <= ST_IDLE;
                    prdata_q  <= '0;
                    pslverr_q <= 1'b0;
                    pready_q  <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    prdata_q  <= '0;
                    pslverr_q <= 1'b0;
                    pready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign apb.prdata  = prdata_q;
    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;
    assign wr_en_o     = wr_en_q;
    assign rd_en_o     = rd_en_q;
    assign addr_o      = addr_q;
    assign wdata_o     = wdata_q;
    assign wstrb_o     = wstrb_q;

endmodule

// File: tb/tb_apb_slave_bridge.sv
// Directed bench for apb_slave_bridge: write/read latency, delayed ready,
// watchdog timeout, misalignment, back-end error, back-to-back, abort,
// asynchronous reset and (with APB_PROT_EN) protection filtering.
module tb_apb_slave_bridge;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = 4;
    localparam int TIMEOUT = 16;

    logic              pclk = 1'b0;
    logic              presetn = 1'b0;
    logic              wr_en_o;
    logic              rd_en_o;
    logic [ADDR_W-1:0] addr_o;
    logic [DATA_W-1:0] wdata_o;
    logic [STRB_W-1:0] wstrb_o;
    logic [DATA_W-1:0] rdata_i;
    logic              ready_i;
    logic              err_i;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // results of the last run_xfer
    int                res_lat;
    int                res_nwr;
    int                res_nrd;
    int                res_req_cyc;
    int                res_rdy_cyc;
    logic              res_both;
    logic [DATA_W-1:0] res_rdata;
    logic              res_err;
    logic [ADDR_W-1:0] res_addr;
    logic [DATA_W-1:0] res_wdata;
    logic [STRB_W-1:0] res_wstrb;
    int                stray;
    int                prev_rdy;

    apb_slave_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) apb ();

    apb_slave_bridge #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .apb     (apb),
        .wr_en_o (wr_en_o),
        .rd_en_o (rd_en_o),
        .addr_o  (addr_o),
        .wdata_o (wdata_o),
        .wstrb_o (wstrb_o),
        .rdata_i (rdata_i),
        .ready_i (ready_i),
        .err_i   (err_i)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Drives a setup phase in the current cycle, then the access phase until
    // pready. dly = cycles after the request cycle before ready_i (-1 never).
    // Returns in the pready cycle with psel/penable still high.
    task automatic run_xfer(input logic wr, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wdata, input logic [STRB_W-1:0] strb,
                            input int dly, input logic [DATA_W-1:0] rdata, input logic err);
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = wr;
        apb.paddr   = addr;
        apb.pwdata  = wdata;
        apb.pstrb   = strb;
        ready_i = 1'b0;
        rdata_i = '0;
        err_i   = 1'b0;
        res_lat = 0; res_nwr = 0; res_nrd = 0; res_both = 1'b0;
        res_req_cyc = -1; res_rdy_cyc = -1;
        res_rdata = '0; res_err = 1'b0;
        res_addr = '0; res_wdata = '0; res_wstrb = '0;
        tick();
        apb.penable = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (wr_en_o) res_nwr++;
            if (rd_en_o) res_nrd++;
            if (wr_en_o && rd_en_o) res_both = 1'b1;
            if ((wr_en_o || rd_en_o) && res_req_cyc < 0) begin
                res_req_cyc = cyc;
                res_addr    = addr_o;
                res_wdata   = wdata_o;
                res_wstrb   = wstrb_o;
            end
            if (apb.pready) begin
                res_lat     = k;
                res_rdy_cyc = cyc;
                res_rdata   = apb.prdata;
                res_err     = apb.pslverr;
                break;
            end
            ready_i = (k - 1 == dly);
            rdata_i = ready_i ? rdata : '0;
            err_i   = ready_i ? err : 1'b0;
            tick();
        end
        ready_i = 1'b0;
        rdata_i = '0;
        err_i   = 1'b0;
    endtask

    // Leaves the pready cycle, releases the bus and counts any stray activity.
    task automatic idle_bus(input int n);
        stray = 0;
        tick();
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (apb.pready || apb.pslverr || wr_en_o || rd_en_o) stray++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        apb.paddr = '0; apb.pwdata = '0; apb.pstrb = '0;
`ifdef APB_PROT_EN
        apb.pprot = 3'b000;
`endif
        ready_i = 1'b0; rdata_i = '0; err_i = 1'b0;

        // reset values
        repeat (2) @(posedge pclk);
        #1;
        check_val("rst_pready",  64'(apb.pready),  64'h0);
        check_val("rst_pslverr", 64'(apb.pslverr), 64'h0);
        check_val("rst_prdata",  64'(apb.prdata),  64'h0);
        check_val("rst_wr_en",   64'(wr_en_o),     64'h0);
        check_val("rst_rd_en",   64'(rd_en_o),     64'h0);
        check_val("rst_addr",    64'(addr_o),      64'h0);
        check_val("rst_wdata",   64'(wdata_o),     64'h0);
        check_val("rst_wstrb",   64'(wstrb_o),     64'h0);
        presetn = 1'b1;
        tick();

        // aligned write, ready in the request cycle
        run_xfer(1'b1, 12'h010, 32'hA5A5_0001, 4'hF, 0, '0, 1'b0);
        check_val("wr_lat",     64'(res_lat),   64'd2);
        check_val("wr_nwr",     64'(res_nwr),   64'd1);
        check_val("wr_nrd",     64'(res_nrd),   64'd0);
        check_val("wr_addr",    64'(res_addr),  64'h010);
        check_val("wr_wdata",   64'(res_wdata), 64'hA5A5_0001);
        check_val("wr_wstrb",   64'(res_wstrb), 64'hF);
        check_val("wr_pslverr", 64'(res_err),   64'h0);
        idle_bus(2);
        check_val("wr_stray",      64'(stray),   64'd0);
        check_val("wr_wdata_hold", 64'(wdata_o), 64'hA5A5_0001);
        check_val("wr_addr_hold",  64'(addr_o),  64'h010);

        // read with ready delayed 3 cycles; strobes must read back as 0
        run_xfer(1'b0, 12'h004, 32'h0, 4'hF, 3, 32'h0000_00C3, 1'b0);
        check_val("rd_lat",     64'(res_lat),   64'd5);
        check_val("rd_nrd",     64'(res_nrd),   64'd1);
        check_val("rd_nwr",     64'(res_nwr),   64'd0);
        check_val("rd_addr",    64'(res_addr),  64'h004);
        check_val("rd_wstrb",   64'(res_wstrb), 64'h0);
        check_val("rd_prdata",  64'(res_rdata), 64'hC3);
        check_val("rd_pslverr", 64'(res_err),   64'h0);
        idle_bus(2);
        check_val("rd_stray",  64'(stray),       64'd0);
        check_val("rd_prdata_clr", 64'(apb.prdata), 64'h0);

        // watchdog: ready never comes, then a late ready is ignored
        run_xfer(1'b0, 12'h008, 32'h0, 4'h0, -1, '0, 1'b0);
        check_val("to_lat",     64'(res_lat),   64'd17);
        check_val("to_nrd",     64'(res_nrd),   64'd1);
        check_val("to_pslverr", 64'(res_err),   64'h1);
        check_val("to_prdata",  64'(res_rdata), 64'h0);
        ready_i = 1'b1; rdata_i = 32'hFF; err_i = 1'b1;
        idle_bus(4);
        ready_i = 1'b0; rdata_i = '0; err_i = 1'b0;
        check_val("to_late_stray", 64'(stray),      64'd0);
        check_val("to_late_prdata", 64'(apb.prdata), 64'h0);

        // misaligned write
        run_xfer(1'b1, 12'h013, 32'h1234_5678, 4'hF, 0, '0, 1'b0);
        check_val("mis_lat",     64'(res_lat), 64'd1);
        check_val("mis_nwr",     64'(res_nwr), 64'd0);
        check_val("mis_nrd",     64'(res_nrd), 64'd0);
        check_val("mis_pslverr", 64'(res_err), 64'h1);
        idle_bus(2);
        check_val("mis_stray", 64'(stray), 64'd0);

        // back-end error on write, then back-to-back read
        run_xfer(1'b1, 12'h020, 32'hCAFE_0002, 4'h3, 0, 32'hFFFF_FFFF, 1'b1);
        check_val("err_lat",     64'(res_lat),   64'd2);
        check_val("err_pslverr", 64'(res_err),   64'h1);
        check_val("err_prdata",  64'(res_rdata), 64'h0);
        check_val("err_wstrb",   64'(res_wstrb), 64'h3);
        prev_rdy = res_rdy_cyc;
        tick();
        run_xfer(1'b0, 12'h024, 32'h0, 4'h0, 0, 32'h1234_5678, 1'b0);
        check_val("b2b_req_cyc", 64'(res_req_cyc - prev_rdy), 64'd2);
        check_val("b2b_lat",     64'(res_lat),   64'd2);
        check_val("b2b_prdata",  64'(res_rdata), 64'h1234_5678);
        check_val("b2b_pslverr", 64'(res_err),   64'h0);
        idle_bus(2);

        // abort: psel dropped while waiting, back-end reply arrives anyway
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = 12'h030;
        tick();
        apb.penable = 1'b1;
        check_val("abt_rd_en", 64'(rd_en_o), 64'h1);
        tick();
        apb.psel = 1'b0; apb.penable = 1'b0;
        ready_i = 1'b1; rdata_i = 32'hDEAD_BEEF;
        stray = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            ready_i = 1'b0; rdata_i = '0;
            if (apb.pready || wr_en_o || rd_en_o || (apb.prdata != '0)) stray++;
        end
        check_val("abt_stray", 64'(stray), 64'd0);
        run_xfer(1'b0, 12'h004, 32'h0, 4'h0, 1, 32'h0000_0055, 1'b0);
        check_val("abt_recover_lat",    64'(res_lat),   64'd3);
        check_val("abt_recover_prdata", 64'(res_rdata), 64'h55);
        idle_bus(2);

        // asynchronous reset during the request cycle
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
        apb.paddr = 12'h040; apb.pwdata = 32'h0BAD_F00D; apb.pstrb = 4'hF;
        tick();
        apb.penable = 1'b1;
        check_val("arst_pre_wr_en", 64'(wr_en_o), 64'h1);
        #2 presetn = 1'b0;
        #1;
        check_val("arst_wr_en", 64'(wr_en_o), 64'h0);
        check_val("arst_addr",  64'(addr_o),  64'h0);
        check_val("arst_wdata", 64'(wdata_o), 64'h0);
        apb.psel = 1'b0; apb.penable = 1'b0;
        tick();
        presetn = 1'b1;
        stray = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (apb.pready || wr_en_o || rd_en_o) stray++;
        end
        check_val("arst_stray", 64'(stray), 64'd0);

`ifdef APB_PROT_EN
        // non-secure access to the secure region is refused
        apb.pprot = 3'b010;
        run_xfer(1'b1, 12'h900, 32'h1111_2222, 4'hF, 0, '0, 1'b0);
        check_val("prot_ns_lat",     64'(res_lat),   64'd1);
        check_val("prot_ns_nwr",     64'(res_nwr),   64'd0);
        check_val("prot_ns_pslverr", 64'(res_err),   64'h1);
        check_val("prot_ns_prdata",  64'(res_rdata), 64'h0);
        idle_bus(2);
        apb.pprot = 3'b000;
        run_xfer(1'b1, 12'h900, 32'h1111_2222, 4'hF, 0, '0, 1'b0);
        check_val("prot_s_lat",     64'(res_lat),  64'd2);
        check_val("prot_s_nwr",     64'(res_nwr),  64'd1);
        check_val("prot_s_addr",    64'(res_addr), 64'h900);
        check_val("prot_s_pslverr", 64'(res_err),  64'h0);
        idle_bus(2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
